wb_timer_monitor: RTL and testbench
===================================

// Module: wb_timer_monitor
// PURPOSE
//  Wishbone slave that sits downstream of the digit timer and gives the bus master control over it.
//  - Drives the timer's enable.
//  - Consumes the timer's tick pulse and digit value.
//  - Counts ticks, captures the digit on every tick, compares the count against a programmable value.
//  - Raises a level interrupt on match or counter overflow.
// PARAMETERS
//  CNT_W    32   tick counter width (1..32); COUNT/COMPARE zero-extended to 32 on read
//  DIGIT_W  4    width of timer digit input
// PORTS
//  clk         in   1        system clock; all state on rising edge
//  rst         in   1        asynchronous, active-high reset
//  wb_adr_i    in   32       byte address; only [4:2] decoded
//  wb_dat_i    in   32       write data
//  wb_sel_i    in   4        byte enables for writes
//  wb_cyc_i    in   1        bus cycle
//  wb_stb_i    in   1        strobe
//  wb_we_i     in   1        1=write, 0=read
//  wb_dat_o    out  32       read data, valid while wb_ack_o=1
//  wb_ack_o    out  1        single-cycle acknowledge
//  tick_i      in   1        one-clk pulse from timer per digit wrap
//  digit_i     in   DIGIT_W  timer's current display digit
//  enable_o    out  1        to timer enable; mirrors CTRL.en
//  irq_o       out  1        level interrupt
// BEHAVIOUR
//  Reset values (async): all registers 0; wb_ack_o=0, wb_dat_o=0, enable_o=0, irq_o=0.
//  Register map (adr[4:2]):
//   0 CTRL    RW  [0] en, [1] irq_en, [2] clr (write-1 pulse, reads 0)
//   1 STATUS  W1C [0] match, [1] ovf
//   2 COUNT   RO  tick counter
//   3 COMPARE RW  match value
//   4 DIGIT   RO  [DIGIT_W-1:0] digit captured at last counted tick
//   5-7           read 0, writes ignored
//  Bus handshake:
//   - Request = wb_cyc_i & wb_stb_i & ~wb_ack_o.
//   - Ack registered: asserted exactly 1 clk after request, held 1 clk. Back-to-back access gets ack every 2nd clk.
//   - Write side effects and read-data capture take effect on the edge that raises ack.
//   - wb_dat_o registered; 0 when ack=0.
//   - Dropping stb/cyc before ack: ack still issues next clk, ignored by master; no further side effect.
//  Byte enables:
//   - Writes to CTRL and COMPARE honour wb_sel_i per byte.
//   - STATUS W1C and CTRL.clr act only if byte 0 is selected.
//  Counting:
//   - A tick is counted only when tick_i=1 and CTRL.en=1; ticks while disabled are ignored.
//   - Counted tick: COUNT <= COUNT+1 modulo 2^CNT_W; DIGIT <= digit_i.
//   - COUNT wrapping from all-ones to 0 sets ovf.
//   - ovf is NOT set when COUNT is zeroed by clr.
//   - match sets on the edge where the new COUNT equals COMPARE due to a counted tick; no set from COMPARE writes or clr.
//  Simultaneous events:
//   - clr and counted tick in same clk: clr wins, COUNT=0, DIGIT still updates.
//   - W1C and hardware set of the same STATUS bit in same clk: set wins (bit ends 1).
//   - CTRL.en write and tick in same clk: tick gated by old en value.
//   - COMPARE write and tick in same clk: match evaluated against old COMPARE.
//  Outputs:
//   - enable_o = CTRL.en (registered, no comb path from bus).
//   - irq_o = CTRL.irq_en & (match | ovf), registered version of that expression (1 clk after source change).
//  Reset mid-operation: async reset clears everything immediately, incl. in-flight ack; the pending bus cycle is lost.
// STRUCTURE
//  Package wb_timer_pkg:
//   - Register offset localparams (CTRL/STATUS/COUNT/COMPARE/DIGIT).
//   - CTRL/STATUS bit index constants, shared with software headers.
//  Sub-module wb_slave_if: bus handshake, ack generation, address decode, byte-lane write strobes.
//  Top holds the register file, counter, compare and irq logic.
// TESTING
//  1 Reset: assert rst mid-access -> ack, irq_o, enable_o, all reads 0 after release.
//  2 Write CTRL=0x1, pulse tick_i 3x with digit_i=7 -> enable_o=1, COUNT=3, DIGIT=7, each ack exactly 1 clk.
//  3 COMPARE=5, CTRL=0x3, 5 ticks -> STATUS=0x1, irq_o=1 one clk after; write STATUS=0x1 -> irq_o=0.
//  4 CNT_W=4, 16 ticks -> COUNT=0, STATUS.ovf=1; W1C on same clk as 32nd tick -> ovf stays 1.
//  5 CTRL=0x5 (en+clr) coincident with tick -> COUNT=0, CTRL reads 0x1.
//  6 Ticks with en=0 -> COUNT unchanged; wb_sel_i=0x2 write to COMPARE=0xFFFF -> COMPARE=0x0000FF00.

Source files
------------

// File: rtl/wb_timer_pkg.sv
// Purpose: register map and bit positions for the Wishbone timer monitor.
//   Register indices are word offsets (byte address bits [4:2]); bit
//   positions are shared with software headers.
package wb_timer_pkg;

  localparam logic [2:0] RegCtrl    = 3'd0;
  localparam logic [2:0] RegStatus  = 3'd1;
  localparam logic [2:0] RegCount   = 3'd2;
  localparam logic [2:0] RegCompare = 3'd3;
  localparam logic [2:0] RegDigit   = 3'd4;

  localparam int unsigned CtrlEnBit      = 0;
  localparam int unsigned CtrlIrqEnBit   = 1;
  localparam int unsigned CtrlClrBit     = 2;
  localparam int unsigned StatusMatchBit = 0;
  localparam int unsigned StatusOvfBit   = 1;

  // Byte address of a register given its word index.
  function automatic logic [31:0] reg_offset(input logic [2:0] idx);
    return {27'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/wb_timer_monitor_if.sv
// Purpose: Wishbone classic slave bus bundle for the timer monitor.
//   Signal names keep the slave-side direction suffixes.
//   master modport: drives address/data/select/cycle/strobe/we, sees data/ack.
//   slave  modport: the reverse.
interface wb_timer_monitor_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_slave_if.sv
// Purpose: Wishbone handshake for the timer monitor. Registers ack one clock
//   after a request, captures read data on that same edge, and exposes the
//   decoded register index, byte lanes and a write strobe to the register file.
// Ports:
//   clk, rst     clock, async active-high reset
//   wb           Wishbone slave modport
//   i_rdata      read data for the currently addressed register
//   o_wr_en      write takes effect on this clock's rising edge
//   o_reg_idx    word index (adr[4:2])
//   o_byte_en    byte lane enables for writes
module wb_slave_if (
  input  logic              clk,
  input  logic              rst,
  wb_timer_monitor_if.slave wb,
  input  logic [31:0]       i_rdata,
  output logic              o_wr_en,
  output logic [2:0]        o_reg_idx,
  output logic [3:0]        o_byte_en
);

  logic        r_ack;
  logic [31:0] r_dat;
  logic        w_req;
  logic        w_unused_adr;

  // Gating with ack makes a held strobe produce ack on every second clock.
  assign w_req     = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
  assign o_wr_en   = w_req & wb.wb_we_i;
  assign o_reg_idx = wb.wb_adr_i[4:2];
  assign o_byte_en = wb.wb_sel_i;

  assign w_unused_adr = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req & ~wb.wb_we_i) ? i_rdata : '0;
    end
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_dat_o = r_dat;

endmodule

// File: rtl/wb_timer_monitor.sv
// Purpose: Wishbone-controlled monitor for the digit timer. Drives the timer
//   enable, counts enabled ticks, captures the digit per counted tick, flags
//   compare matches and counter overflow, and raises a level interrupt.
// Ports:
//   clk, rst     clock, async active-high reset
//   wb           Wishbone slave modport
//   tick_i       one-clock tick pulse from the timer
//   digit_i      timer's current digit
//   enable_o     timer enable (CTRL.en)
//   irq_o        registered irq_en & (match | ovf)
module wb_timer_monitor
  import wb_timer_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  wb_timer_monitor_if.slave  wb,
  input  logic               tick_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic               enable_o,
  output logic               irq_o
);

  logic               r_en;
  logic               r_irq_en;
  logic               r_match;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_compare;
  logic [DIGIT_W-1:0] r_digit;
  logic               r_irq;

  logic        w_wr_en;
  logic [2:0]  w_reg_idx;
  logic [3:0]  w_byte_en;
  logic [31:0] w_rdata;
  logic [31:0] w_cmp_merged;
  logic        w_unused_cmp;

  logic             w_ctrl_wr;
  logic             w_status_w1c;
  logic             w_cmp_wr;
  logic             w_clr;
  logic             w_tick;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_wrap;
  logic             w_hit;
  logic             w_clr_match;
  logic             w_clr_ovf;

  wb_slave_if u_slave (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .i_rdata   (w_rdata),
    .o_wr_en   (w_wr_en),
    .o_reg_idx (w_reg_idx),
    .o_byte_en (w_byte_en)
  );

  assign w_ctrl_wr    = w_wr_en && (w_reg_idx == RegCtrl) && w_byte_en[0];
  assign w_status_w1c = w_wr_en && (w_reg_idx == RegStatus) && w_byte_en[0];
  assign w_cmp_wr     = w_wr_en && (w_reg_idx == RegCompare);
  assign w_clr        = w_ctrl_wr & wb.wb_dat_i[CtrlClrBit];

  // Gated by the enable currently held, not one being written this clock.
  assign w_tick      = tick_i & r_en;
  assign w_count_inc = r_count + CNT_W'(1);
  // A clear in the same clock overrides the tick's count result, so neither
  // wrap nor match is flagged then.
  assign w_wrap      = w_tick & ~w_clr & (r_count == '1);
  assign w_hit       = w_tick & ~w_clr & (w_count_inc == r_compare);
  assign w_clr_match = w_status_w1c & wb.wb_dat_i[StatusMatchBit];
  assign w_clr_ovf   = w_status_w1c & wb.wb_dat_i[StatusOvfBit];

  always_comb begin
    w_cmp_merged = 32'(r_compare);
    for (int b = 0; b < 4; b++) begin
      if (w_byte_en[b]) w_cmp_merged[8*b +: 8] = wb.wb_dat_i[8*b +: 8];
    end
  end
  assign w_unused_cmp = ^w_cmp_merged;

  always_comb begin
    w_rdata = '0;
    case (w_reg_idx)
      RegCtrl: begin
        w_rdata[CtrlEnBit]    = r_en;
        w_rdata[CtrlIrqEnBit] = r_irq_en;
      end
      RegStatus: begin
        w_rdata[StatusMatchBit] = r_match;
        w_rdata[StatusOvfBit]   = r_ovf;
      end
      RegCount:   w_rdata = 32'(r_count);
      RegCompare: w_rdata = 32'(r_compare);
      RegDigit:   w_rdata = 32'(r_digit);
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en      <= 1'b0;
      r_irq_en  <= 1'b0;
      r_match   <= 1'b0;
      r_ovf     <= 1'b0;
      r_count   <= '0;
      r_compare <= '0;
      r_digit   <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_en     <= wb.wb_dat_i[CtrlEnBit];
        r_irq_en <= wb.wb_dat_i[CtrlIrqEnBit];
      end
      if (w_cmp_wr) r_compare <= w_cmp_merged[CNT_W-1:0];
      if (w_tick) begin
        r_count <= w_count_inc;
        r_digit <= digit_i;
      end
      if (w_clr) r_count <= '0;
      // Hardware set beats a software clear in the same clock.
      r_match <= (r_match & ~w_clr_match) | w_hit;
      r_ovf   <= (r_ovf & ~w_clr_ovf) | w_wrap;
      r_irq   <= r_irq_en & (r_match | r_ovf);
    end
  end

  assign enable_o = r_en;
  assign irq_o    = r_irq;

endmodule

// File: tb/tb_wb_timer_monitor.sv
module tb_wb_timer_monitor;
  import wb_timer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tick0 = 1'b0, tick1 = 1'b0;
  logic [3:0] digit0 = '0, digit1 = '0;
  logic       en0, en1, irq0, irq1;

  wb_timer_monitor_if bus0 ();
  wb_timer_monitor_if bus1 ();

  wb_timer_monitor #(.CNT_W(32), .DIGIT_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .wb(bus0), .tick_i(tick0), .digit_i(digit0),
    .enable_o(en0), .irq_o(irq0)
  );

  wb_timer_monitor #(.CNT_W(4), .DIGIT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .wb(bus1), .tick_i(tick1), .digit_i(digit1),
    .enable_o(en1), .irq_o(irq1)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] exp;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  logic prev_ack0 = 1'b0, prev_ack1 = 1'b0;

  localparam logic [31:0] ACtrl = 32'h00;
  localparam logic [31:0] AStat = 32'h04;
  localparam logic [31:0] ACnt  = 32'h08;
  localparam logic [31:0] ACmp  = 32'h0C;
  localparam logic [31:0] ADig  = 32'h10;
  localparam logic [31:0] A5    = 32'h14;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard side: every ack pops one expectation.
  task automatic mon(input int d, input logic [31:0] dat, input logic prev);
    exp_t e;
    checks++;
    if (prev) begin
      failures++;
      $display("FAIL ack_width dut%0d: ack got 2 clks expected 1", d);
    end
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      failures++;
      $display("FAIL unexpected_ack dut%0d: got ack expected none", d);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (dat !== e.exp) begin
      failures++;
      $display("FAIL %s dut%0d adr 0x%02h: got 0x%08h expected 0x%08h",
               e.we ? "wr_dat" : "rd_dat", d, e.adr, dat, e.exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus0.wb_ack_o === 1'b1) mon(0, bus0.wb_dat_o, prev_ack0);
    if (bus1.wb_ack_o === 1'b1) mon(1, bus1.wb_dat_o, prev_ack1);
    prev_ack0 = bus0.wb_ack_o;
    prev_ack1 = bus1.wb_ack_o;
  end

  task automatic set_bus(input int d, input logic act, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
    if (d == 0) begin
      bus0.wb_cyc_i = act; bus0.wb_stb_i = act; bus0.wb_we_i = we;
      bus0.wb_adr_i = adr; bus0.wb_dat_i = dat; bus0.wb_sel_i = sel;
    end else begin
      bus1.wb_cyc_i = act; bus1.wb_stb_i = act; bus1.wb_we_i = we;
      bus1.wb_adr_i = adr; bus1.wb_dat_i = dat; bus1.wb_sel_i = sel;
    end
  endtask

  task automatic set_tick(input int d, input logic t, input logic [3:0] dig);
    if (d == 0) begin tick0 = t; digit0 = dig; end
    else        begin tick1 = t; digit1 = dig; end
  endtask

  function automatic logic get_ack(input int d);
    return (d == 0) ? bus0.wb_ack_o : bus1.wb_ack_o;
  endfunction

  // One bus access; optionally a tick on the same edge that raises ack.
  task automatic access(input int d, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input logic [31:0] exp,
                        input logic with_tick, input logic [3:0] tdig);
    exp_t e;
    logic got;
    if (get_ack(d)) begin @(posedge clk); #1; end
    e.we = we; e.adr = adr; e.exp = we ? 32'h0 : exp;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    set_bus(d, 1'b1, we, adr, dat, sel);
    if (with_tick) set_tick(d, 1'b1, tdig);
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      set_tick(d, 1'b0, tdig);
      got = get_ack(d);
    end
    set_bus(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk($sformatf("ack_timeout dut%0d adr 0x%02h", d, adr), {31'b0, got}, 32'h1);
  endtask

  task automatic wr(input int d, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel);
    access(d, 1'b1, adr, dat, sel, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic rd(input int d, input logic [31:0] adr, input logic [31:0] exp);
    access(d, 1'b0, adr, 32'h0, 4'hF, exp, 1'b0, 4'h0);
  endtask

  // Each pulse preceded by an idle clock; returns just after the counted edge.
  task automatic tk(input int d, input logic [3:0] dig, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      set_tick(d, 1'b1, dig);
      @(posedge clk); #1;
      set_tick(d, 1'b0, dig);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_bus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_bus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ack", {31'b0, bus0.wb_ack_o}, 32'h0);
    chk("rst_en", {31'b0, en0}, 32'h0);
    chk("rst_irq", {31'b0, irq0}, 32'h0);

    // Reset lands while ack of a CTRL.en write is high.
    @(posedge clk); #1;
    set_bus(0, 1'b1, 1'b1, ACtrl, 32'h1, 4'hF);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_ack", {31'b0, bus0.wb_ack_o}, 32'h0);
    chk("midrst_en", {31'b0, en0}, 32'h0);
    chk("midrst_irq", {31'b0, irq0}, 32'h0);
    set_bus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) rd(0, reg_offset(3'(i)), 32'h0);
    rd(1, ACtrl, 32'h0);

    // Enable and count three ticks.
    wr(0, ACtrl, 32'h1, 4'hF);
    chk("en_after_ctrl", {31'b0, en0}, 32'h1);
    tk(0, 4'd7, 3);
    rd(0, ACnt, 32'd3);
    rd(0, ADig, 32'd7);
    rd(0, ACtrl, 32'h1);

    // Compare match and irq.
    wr(0, ACmp, 32'd5, 4'hF);
    wr(0, ACtrl, 32'h7, 4'hF);
    rd(0, ACtrl, 32'h3);
    rd(0, ACnt, 32'd0);
    tk(0, 4'd2, 4);
    chk("irq_before_match", {31'b0, irq0}, 32'h0);
    tk(0, 4'd2, 1);
    chk("irq_match_edge", {31'b0, irq0}, 32'h0);
    @(posedge clk); #1;
    chk("irq_match_next", {31'b0, irq0}, 32'h1);
    rd(0, AStat, 32'h1);
    rd(0, ADig, 32'd2);
    wr(0, AStat, 32'h1, 4'h2);
    rd(0, AStat, 32'h1);
    wr(0, AStat, 32'h1, 4'h1);
    @(posedge clk); #1;
    chk("irq_after_w1c", {31'b0, irq0}, 32'h0);
    rd(0, AStat, 32'h0);

    // en+clr coincident with a counted tick.
    access(0, 1'b1, ACtrl, 32'h5, 4'hF, 32'h0, 1'b1, 4'd9);
    rd(0, ACnt, 32'd0);
    rd(0, ADig, 32'd9);
    rd(0, ACtrl, 32'h1);
    rd(0, AStat, 32'h0);
    chk("irq_after_clr", {31'b0, irq0}, 32'h0);

    // Disabled ticks, en write gated by old en, byte-lane COMPARE write.
    wr(0, ACtrl, 32'h0, 4'hF);
    chk("en_off", {31'b0, en0}, 32'h0);
    tk(0, 4'd3, 2);
    rd(0, ACnt, 32'd0);
    access(0, 1'b1, ACtrl, 32'h1, 4'hF, 32'h0, 1'b1, 4'd4);
    rd(0, ACnt, 32'd0);
    rd(0, ADig, 32'd9);
    chk("en_on", {31'b0, en0}, 32'h1);
    wr(0, ACmp, 32'h0, 4'hF);
    wr(0, ACmp, 32'h0000FFFF, 4'h2);
    rd(0, ACmp, 32'h0000FF00);
    wr(0, A5, 32'hFFFFFFFF, 4'hF);
    rd(0, A5, 32'h0);

    // COMPARE write with tick: match uses the old value.
    wr(0, ACmp, 32'd1, 4'hF);
    access(0, 1'b1, ACmp, 32'd7, 4'hF, 32'h0, 1'b1, 4'd5);
    rd(0, AStat, 32'h1);
    rd(0, ACmp, 32'd7);
    rd(0, ACnt, 32'd1);

    // 4-bit counter: overflow and W1C collision.
    wr(1, ACtrl, 32'h1, 4'hF);
    wr(1, ACmp, 32'hFFFFFFFF, 4'hF);
    rd(1, ACmp, 32'hF);
    tk(1, 4'd5, 16);
    rd(1, ACnt, 32'd0);
    rd(1, AStat, 32'h3);
    rd(1, ADig, 32'd5);
    wr(1, AStat, 32'h3, 4'h1);
    rd(1, AStat, 32'h0);
    tk(1, 4'd6, 15);
    rd(1, ACnt, 32'hF);
    rd(1, AStat, 32'h1);
    access(1, 1'b1, AStat, 32'h2, 4'h1, 32'h0, 1'b1, 4'd8);
    rd(1, AStat, 32'h3);
    rd(1, ACnt, 32'd0);
    rd(1, ADig, 32'd8);
    chk("irq1_disabled", {31'b0, irq1}, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_q0", 32'(q0.size()), 32'h0);
    chk("pending_q1", 32'(q1.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
